// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the unified-memory arbiter: transfer direction codes
// and the arbiter FSM state encoding.
package mem_arbiter_pkg;

  localparam logic DIRECTION_READ  = 1'b0;
  localparam logic DIRECTION_WRITE = 1'b1;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_I = 2'd1,
    ARB_BUSY_D = 2'd2,
    ARB_ACK    = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-input round-robin pick: a lone request wins outright, a tie goes to the
// port that was not granted last.
module rr_arb2 (
  input  logic i_req,
  input  logic d_req,
  input  logic last_d,
  output logic grant_i,
  output logic grant_d
);

  assign grant_i = i_req & (~d_req | last_d);
  assign grant_d = d_req & (~i_req | ~last_d);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between the fetch (i_*) and data (d_*) ports
// of bfcpu, one transaction outstanding at a time, round-robin on contention.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int              M_AW   = 17,
  parameter logic [M_AW-1:0] D_BASE = M_AW'(17'h10000)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req,
  input  logic [15:0]     i_addr,
  output logic            i_ack,
  output logic [7:0]      i_rdata,
  input  logic            d_req,
  input  logic            d_dir,
  input  logic [7:0]      d_addr,
  input  logic [7:0]      d_wdata,
  output logic            d_ack,
  output logic [7:0]      d_rdata,
  output logic            m_req,
  output logic            m_dir,
  output logic [M_AW-1:0] m_addr,
  output logic [7:0]      m_wdata,
  input  logic            m_ack,
  input  logic [7:0]      m_rdata
);

  arb_state_t      state_reg, state_next;
  logic            last_d_reg, last_d_next;
  logic            m_req_next, m_dir_next;
  logic [M_AW-1:0] m_addr_next;
  logic [7:0]      m_wdata_next;
  logic            i_ack_next, d_ack_next;
  logic [7:0]      i_rdata_next, d_rdata_next;
  logic            grant_i, grant_d;

  rr_arb2 u_rr_arb2 (
    .i_req   (i_req),
    .d_req   (d_req),
    .last_d  (last_d_reg),
    .grant_i (grant_i),
    .grant_d (grant_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ARB_IDLE;
      last_d_reg <= 1'b1;
      m_req      <= 1'b0;
      m_dir      <= DIRECTION_READ;
      m_addr     <= '0;
      m_wdata    <= '0;
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      state_reg  <= state_next;
      last_d_reg <= last_d_next;
      m_req      <= m_req_next;
      m_dir      <= m_dir_next;
      m_addr     <= m_addr_next;
      m_wdata    <= m_wdata_next;
      i_ack      <= i_ack_next;
      d_ack      <= d_ack_next;
      i_rdata    <= i_rdata_next;
      d_rdata    <= d_rdata_next;
    end
  end

  // Requester inputs are only looked at in IDLE; the command registers then
  // hold the granted transaction until the memory acknowledges it.
  always_comb begin
    state_next   = state_reg;
    last_d_next  = last_d_reg;
    m_req_next   = m_req;
    m_dir_next   = m_dir;
    m_addr_next  = m_addr;
    m_wdata_next = m_wdata;
    i_ack_next   = 1'b0;
    d_ack_next   = 1'b0;
    i_rdata_next = i_rdata;
    d_rdata_next = d_rdata;

    case (state_reg)
      ARB_IDLE: begin
        if (grant_i) begin
          m_addr_next = M_AW'(i_addr);
          m_dir_next  = DIRECTION_READ;
          m_req_next  = 1'b1;
          last_d_next = 1'b0;
          state_next  = ARB_BUSY_I;
        end else if (grant_d) begin
          m_addr_next  = D_BASE + M_AW'(d_addr);
          m_dir_next   = d_dir;
          m_wdata_next = d_wdata;
          m_req_next   = 1'b1;
          last_d_next  = 1'b1;
          state_next   = ARB_BUSY_D;
        end
      end

      ARB_BUSY_I: begin
        if (m_ack) begin
          m_req_next   = 1'b0;
          i_rdata_next = m_rdata;
          i_ack_next   = 1'b1;
          state_next   = ARB_ACK;
        end
      end

      ARB_BUSY_D: begin
        if (m_ack) begin
          m_req_next = 1'b0;
          if (m_dir == DIRECTION_READ) begin
            d_rdata_next = m_rdata;
          end
          d_ack_next = 1'b1;
          state_next = ARB_ACK;
        end
      end

      ARB_ACK: begin
        state_next = ARB_IDLE;
      end

      default: begin
        state_next = ARB_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table-driven single transactions, hand
// sequences for contention/latency/reset corners, and randomized traffic.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int          M_AW   = 17;
  localparam logic [16:0] D_BASE = 17'h10000;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, i_ack;
  logic [15:0] i_addr;
  logic [7:0]  i_rdata;
  logic        d_req, d_dir, d_ack;
  logic [7:0]  d_addr, d_wdata, d_rdata;
  logic        m_req, m_dir, m_ack;
  logic [16:0] m_addr;
  logic [7:0]  m_wdata, m_rdata;

  mem_arbiter #(.M_AW(M_AW), .D_BASE(D_BASE)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_dir(d_dir), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .m_req(m_req), .m_dir(m_dir), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: memory contents are a fixed function of address until the
  // data port writes a byte; outputs follow from the spec's address mapping.
  logic [7:0] ref_wr [int];
  logic [7:0] exp_i_rdata = 8'h00;
  logic [7:0] exp_d_rdata = 8'h00;

  function automatic logic [7:0] init_byte(input logic [16:0] a);
    return a[7:0] ^ a[15:8] ^ {7'd0, a[16]} ^ 8'h7C;
  endfunction

  function automatic logic [7:0] model_read(input logic [16:0] a);
    if (ref_wr.exists(int'(a))) return ref_wr[int'(a)];
    return init_byte(a);
  endfunction

  function automatic logic [16:0] fetch_addr(input logic [15:0] a);
    return {1'b0, a};
  endfunction

  function automatic logic [16:0] data_addr(input logic [7:0] a);
    return 17'h10000 + {9'd0, a};
  endfunction

  // Memory responder
  logic [7:0]  mem [0:131071];
  int          mem_lat = 1;
  bit          rand_lat = 1'b0;
  int          stray_req = 0;
  int          stray_done = 0;

  initial begin : responder
    int          cnt;
    int          cur_lat;
    logic [16:0] hold_addr;
    logic        hold_dir;
    logic [7:0]  hold_wdata;
    bit          ok;
    cnt = 0;
    cur_lat = 1;
    hold_addr = '0;
    hold_dir = 1'b0;
    hold_wdata = '0;
    m_ack = 1'b0;
    m_rdata = 8'h00;
    for (int a = 0; a < 131072; a++) mem[a] = init_byte(17'(a));
    forever begin
      @(posedge clk);
      #1;
      m_ack = 1'b0;
      if (!rst) chk("ack_exclusive", {31'd0, i_ack & d_ack}, 32'd0);
      if (rst || !m_req) begin
        cnt = 0;
        if (!rst && stray_req != stray_done) begin
          m_ack = 1'b1;
          m_rdata = 8'hEE;
          stray_done = stray_req;
        end
      end else begin
        if (cnt == 0) begin
          hold_addr  = m_addr;
          hold_dir   = m_dir;
          hold_wdata = m_wdata;
          cur_lat    = rand_lat ? int'($urandom_range(1, 4)) : mem_lat;
          ok = (i_req && m_addr == fetch_addr(i_addr) && m_dir == DIRECTION_READ) ||
               (d_req && m_addr == data_addr(d_addr) && m_dir == d_dir &&
                (d_dir == DIRECTION_READ || m_wdata == d_wdata));
          chk("grant_cmd", {31'd0, ok}, 32'd1);
        end else begin
          chk("m_cmd_stable", {6'd0, m_addr, m_dir, m_wdata}, {6'd0, hold_addr, hold_dir, hold_wdata});
        end
        cnt++;
        if (cnt == cur_lat + 1) begin
          m_ack = 1'b1;
          if (m_dir == DIRECTION_WRITE) mem[m_addr] = m_wdata;
          else m_rdata = mem[m_addr];
          cnt = 0;
        end
      end
    end
  end

  typedef struct {
    bit          port_d;
    logic        dir;
    logic [15:0] addr;
    logic [7:0]  wdata;
    int          lat;
    logic [16:0] exp_maddr;
  } vec_t;

  vec_t vecs [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    exp_i_rdata = 8'h00;
    exp_d_rdata = 8'h00;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_m_req"}, {31'd0, m_req}, 32'd0);
    chk({tag, "_m_dir"}, {31'd0, m_dir}, {31'd0, DIRECTION_READ});
    chk({tag, "_m_addr"}, {15'd0, m_addr}, 32'd0);
    chk({tag, "_m_wdata"}, {24'd0, m_wdata}, 32'd0);
    chk({tag, "_acks"}, {30'd0, i_ack, d_ack}, 32'd0);
    chk({tag, "_i_rdata"}, {24'd0, i_rdata}, 32'd0);
    chk({tag, "_d_rdata"}, {24'd0, d_rdata}, 32'd0);
  endtask

  task automatic do_txn(input int idx, input vec_t v);
    int          cyc;
    bit          seen, got, other;
    logic [16:0] cap_addr;
    logic        cap_dir;
    logic [7:0]  cap_wdata;
    logic [16:0] a;
    cyc = 0; seen = 0; got = 0; other = 0;
    cap_addr = '0; cap_dir = 1'b0; cap_wdata = '0;
    mem_lat = v.lat;
    if (v.port_d) begin
      d_req = 1'b1; d_dir = v.dir; d_addr = v.addr[7:0]; d_wdata = v.wdata;
    end else begin
      i_req = 1'b1; i_addr = v.addr;
    end
    while (cyc < 100 && !got) begin
      step();
      cyc++;
      if (m_req && !seen) begin
        seen = 1; cap_addr = m_addr; cap_dir = m_dir; cap_wdata = m_wdata;
      end
      if (v.port_d ? i_ack : d_ack) other = 1;
      got = v.port_d ? d_ack : i_ack;
    end
    chk("ack_seen", {31'd0, got}, 32'd1);
    chk("latency", cyc, v.lat + 2);
    chk("m_addr", {15'd0, cap_addr}, {15'd0, v.exp_maddr});
    chk("m_dir", {31'd0, cap_dir}, {31'd0, v.port_d ? v.dir : DIRECTION_READ});
    if (v.port_d && v.dir == DIRECTION_WRITE) chk("m_wdata", {24'd0, cap_wdata}, {24'd0, v.wdata});
    chk("other_ack", {31'd0, other}, 32'd0);
    if (!v.port_d) begin
      exp_i_rdata = model_read(fetch_addr(v.addr));
    end else begin
      a = data_addr(v.addr[7:0]);
      if (v.dir == DIRECTION_READ) exp_d_rdata = model_read(a);
      else ref_wr[int'(a)] = v.wdata;
    end
    chk("i_rdata", {24'd0, i_rdata}, {24'd0, exp_i_rdata});
    chk("d_rdata", {24'd0, d_rdata}, {24'd0, exp_d_rdata});
    $display("txn %0d port=%s dir=%0d addr=%h m_addr=%h lat=%0d cycles=%0d i_rdata=%h d_rdata=%h",
             idx, v.port_d ? "D" : "I", v.dir, v.addr, cap_addr, v.lat, cyc, i_rdata, d_rdata);
    i_req = 1'b0;
    d_req = 1'b0;
    step();
    chk("ack_width", {31'd0, i_ack | d_ack}, 32'd0);
  endtask

  task automatic wait_ack(output bit got_i, output bit got_d);
    int cyc;
    cyc = 0; got_i = 0; got_d = 0;
    while (cyc < 200 && !got_i && !got_d) begin
      step();
      cyc++;
      got_i = i_ack;
      got_d = d_ack;
    end
  endtask

  task automatic run_i(input int n);
    logic [15:0] a;
    int cyc;
    bit got;
    for (int k = 0; k < n; k++) begin
      if (!i_req) begin
        repeat ($urandom_range(0, 3)) step();
      end
      a = 16'($urandom);
      i_addr = a;
      i_req = 1'b1;
      cyc = 0; got = 0;
      while (cyc < 200 && !got) begin
        step();
        cyc++;
        got = i_ack;
      end
      chk("rnd_i_ack", {31'd0, got}, 32'd1);
      exp_i_rdata = model_read(fetch_addr(a));
      chk("rnd_i_rdata", {24'd0, i_rdata}, {24'd0, exp_i_rdata});
      $display("rnd I %0d addr=%h cycles=%0d i_rdata=%h", k, a, cyc, i_rdata);
      if (!got || $urandom_range(0, 1) == 0) i_req = 1'b0;
    end
    i_req = 1'b0;
  endtask

  task automatic run_d(input int n);
    logic [7:0] a, w;
    logic       dir;
    int cyc;
    bit got;
    for (int k = 0; k < n; k++) begin
      if (!d_req) begin
        repeat ($urandom_range(0, 3)) step();
      end
      a = 8'($urandom);
      w = 8'($urandom);
      dir = 1'($urandom);
      d_addr = a; d_wdata = w; d_dir = dir;
      d_req = 1'b1;
      cyc = 0; got = 0;
      while (cyc < 200 && !got) begin
        step();
        cyc++;
        got = d_ack;
      end
      chk("rnd_d_ack", {31'd0, got}, 32'd1);
      if (dir == DIRECTION_READ) exp_d_rdata = model_read(data_addr(a));
      else ref_wr[int'(data_addr(a))] = w;
      chk("rnd_d_rdata", {24'd0, d_rdata}, {24'd0, exp_d_rdata});
      $display("rnd D %0d dir=%0d addr=%h wdata=%h cycles=%0d d_rdata=%h", k, dir, a, w, cyc, d_rdata);
      if (!got || $urandom_range(0, 1) == 0) d_req = 1'b0;
    end
    d_req = 1'b0;
  endtask

  initial begin : main
    bit   gi, gd;
    int   cyc, acks;
    rst = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_dir = DIRECTION_READ; d_addr = '0; d_wdata = '0;

    vecs[0] = '{1'b0, DIRECTION_READ,  16'h1234, 8'h00, 1, 17'h01234};
    vecs[1] = '{1'b1, DIRECTION_WRITE, 16'h00FF, 8'hC3, 1, 17'h100FF};
    vecs[2] = '{1'b1, DIRECTION_READ,  16'h00FF, 8'h00, 2, 17'h100FF};
    vecs[3] = '{1'b0, DIRECTION_READ,  16'hFFFF, 8'h00, 3, 17'h0FFFF};
    vecs[4] = '{1'b1, DIRECTION_READ,  16'h0000, 8'h00, 1, 17'h10000};
    vecs[5] = '{1'b1, DIRECTION_WRITE, 16'h0000, 8'h5A, 4, 17'h10000};
    vecs[6] = '{1'b1, DIRECTION_READ,  16'h0000, 8'h00, 1, 17'h10000};
    vecs[7] = '{1'b0, DIRECTION_READ,  16'h0000, 8'h00, 5, 17'h00000};

    step();
    do_reset();
    check_outputs("reset");

    for (int k = 0; k < 8; k++) do_txn(k, vecs[k]);

    // Contention: fetch must win the first tie after reset, then alternate.
    do_reset();
    mem_lat = 1;
    i_addr = 16'h0100; d_addr = 8'h10; d_dir = DIRECTION_READ;
    i_req = 1'b1; d_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wait_ack(gi, gd);
      chk("cont_ack_seen", {31'd0, gi | gd}, 32'd1);
      chk("cont_order", {31'd0, gd}, k % 2);
      if (gd) begin
        exp_d_rdata = model_read(data_addr(d_addr));
        chk("cont_d_rdata", {24'd0, d_rdata}, {24'd0, exp_d_rdata});
        $display("cont %0d grant=D addr=%h d_rdata=%h", k, d_addr, d_rdata);
        d_addr = d_addr + 8'd1;
      end else begin
        exp_i_rdata = model_read(fetch_addr(i_addr));
        chk("cont_i_rdata", {24'd0, i_rdata}, {24'd0, exp_i_rdata});
        $display("cont %0d grant=I addr=%h i_rdata=%h", k, i_addr, i_rdata);
        i_addr = i_addr + 16'd1;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    repeat (3) step();

    // Slow memory with the requester dropping req mid-transaction.
    mem_lat = 5;
    d_dir = DIRECTION_READ; d_addr = 8'h20; d_req = 1'b1;
    cyc = 0;
    while (cyc < 20 && !m_req) begin step(); cyc++; end
    chk("slow_m_req", {31'd0, m_req}, 32'd1);
    step(); step();
    d_req = 1'b0; d_addr = 8'h99;
    wait_ack(gi, gd);
    chk("slow_d_ack", {30'd0, gi, gd}, 32'd1);
    exp_d_rdata = model_read(data_addr(8'h20));
    chk("slow_d_rdata", {24'd0, d_rdata}, {24'd0, exp_d_rdata});
    $display("slow D addr=20 dropped early d_rdata=%h", d_rdata);
    acks = 0;
    stray_req++;
    repeat (6) begin step(); acks += int'(i_ack) + int'(d_ack) + int'(m_req); end
    chk("stray_idle_no_ack", acks, 0);

    // Reset while the data transaction is still in BUSY_D.
    mem_lat = 20;
    d_dir = DIRECTION_READ; d_addr = 8'h30; d_req = 1'b1;
    cyc = 0;
    while (cyc < 20 && !m_req) begin step(); cyc++; end
    chk("rst_m_req_up", {31'd0, m_req}, 32'd1);
    step(); step();
    rst = 1'b1;
    step();
    check_outputs("midrst");
    rst = 1'b0;
    d_req = 1'b0;
    exp_i_rdata = 8'h00; exp_d_rdata = 8'h00;
    stray_req++;
    acks = 0;
    repeat (25) begin step(); acks += int'(i_ack) + int'(d_ack); end
    chk("midrst_no_ack", acks, 0);
    $display("mid-transaction reset done, acks after reset=%0d", acks);
    do_txn(8, '{1'b0, DIRECTION_READ, 16'hBEEF, 8'h00, 1, 17'h0BEEF});

    // Randomized traffic from both ports with random memory latency.
    rand_lat = 1'b1;
    fork
      run_i(40);
      run_d(40);
    join
    repeat (5) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
